mult_datapath: RTL and testbench
================================

MULT_DATAPATH -- requirements
Module: mult_datapath

Interface
REQ-001 Parameter: none; data width fixed at 32 bits via shared package constant.
REQ-002 Clocking: one clock; reset is synchronous and active-high.
REQ-003 Port: clk, input, 1, rising-edge clock for all state.
REQ-004 Port: rst, input, 1, synchronous active-high reset.
REQ-005 Port: product_res, output, 32, upper half of the 64-bit product register.
REQ-006 Port: multipliar_res, output, 32, multiplier register; holds the lower half of the product on completion.
REQ-007 Port: stop, output, 1, high when the iteration count equals 32.
REQ-008 Port: multiplicant, input, 32, unsigned multiplicand, sampled on load.
REQ-009 Port: multipliar, input, 32, unsigned multiplier, sampled on load.
REQ-010 Port: multipliar_sign, input, 1, shift control: shift {carry, hi, multiplier} right by one.
REQ-011 Port: product_sign, input, 1, add control: conditionally add the multiplicand into hi.
REQ-012 Port: start_mult_sign, input, 1, load/start control.
REQ-013 Port: count_sign, input, 1, iteration-counter increment control.

Function
REQ-014 State: mcand[31:0], carry (1 bit), hi[31:0], mplier[31:0], count[5:0]; all registered on clk.
REQ-015 Priority each edge: rst > start_mult_sign > (product_sign / multipliar_sign / count_sign).
REQ-016 Load: start_mult_sign=1 -> mcand<=multiplicant, mplier<=multipliar, hi<=0, carry<=0, count<=0; other controls ignored that cycle.
REQ-017 Add: product_sign=1 and mplier[0]=1 -> {carry,hi} <= hi + mcand (33-bit unsigned sum).
REQ-018 Add: product_sign=1 and mplier[0]=0 -> hi and carry unchanged.
REQ-019 Shift: multipliar_sign=1 -> {carry,hi,mplier} <= {1'b0, carry, hi, mplier[31:1]}, i.e. a 65-bit logical right shift.
REQ-020 Add and shift in the same cycle -> shift operates on the post-add value, completing one full iteration per cycle.
REQ-021 Count: count_sign=1 -> count<=count+1; count saturates at 32.
REQ-022 stop = (count == 32), decoded from the register with no extra latency.
REQ-023 While stop=1, add, shift and count controls are ignored; results hold until the next load or reset.
REQ-024 Outputs are driven directly from registers: product_res=hi, multipliar_res=mplier.
REQ-025 Completion: after 32 iterations from a load, {product_res, multipliar_res} equals multiplicant*multipliar (unsigned, 64-bit).
REQ-026 Latency: with all three controls high each cycle after a one-cycle load, stop rises after the 32nd iteration edge (33 edges including the load).
REQ-027 start_mult_sign held high continuously -> reload every cycle; stop stays 0.

Reset
REQ-028 rst=1 at a clk edge -> mcand, carry, hi, mplier and count all become 0; product_res=0, multipliar_res=0, stop=0.
REQ-029 Reset mid-operation aborts the current multiply with no residual state.

Structure
REQ-030 Shared package mult_pkg: DATA_W=32, CNT_W=6, ITERATIONS=32.
REQ-031 Single module mult_datapath with no sub-module required; the control FSM is a separate block driving the *_sign inputs.

Verification
REQ-032 Reset: rst=1 for one edge -> product_res=0x00000000, multipliar_res=0x00000000, stop=0.
REQ-033 Basic multiply: load 2 x 1, then 32 cycles with all controls high -> product_res=0x00000000, multipliar_res=0x00000002, stop=1.
REQ-034 Carry path: 0xFFFFFFFF x 0xFFFFFFFF -> product_res=0xFFFFFFFE, multipliar_res=0x00000001; split add/shift cycles give the same result.
REQ-035 Start held with all controls high and multiplier=1 -> product_res=0, multipliar_res=0x00000001 every cycle, stop=0.
REQ-036 After stop: 5 extra control cycles leave outputs unchanged; then a load of 3 x 5 clears stop next edge and completes with multipliar_res=0x0000000F.
REQ-037 Reset after 10 iterations -> all outputs 0, stop=0.

Source files
------------

// File: rtl/mult_pkg.sv
// ============================================================================
// Module      : mult_pkg
// Description : Shared constants for the shift-and-add multiplier datapath.
//               DATA_W     - operand width
//               CNT_W      - iteration counter width (must hold ITERATIONS)
//               ITERATIONS - shift/add iterations needed for one product
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package mult_pkg;

   localparam int DATA_W     = 32;
   localparam int CNT_W      = 6;
   localparam int ITERATIONS = 32;

endpackage : mult_pkg

`default_nettype wire

// File: rtl/mult_datapath.sv
// ============================================================================
// Module      : mult_datapath
// Description : Unsigned 32x32 shift-and-add multiplier datapath. An external
//               control FSM sequences it through the *_sign strobes. The
//               64-bit product accumulates in {hi, mplier}. A carry bit
//               catches the overflow of each add. When 32 iterations have
//               been counted, stop asserts and the datapath freezes.
// Ports       :
//   clk              in   rising-edge clock for all state
//   rst              in   synchronous active-high reset
//   product_res      out  [31:0] upper product half (hi register)
//   multipliar_res   out  [31:0] multiplier register / lower product half
//   stop             out  high when the iteration count equals 32
//   multiplicant     in   [31:0] multiplicand, sampled on load
//   multipliar       in   [31:0] multiplier, sampled on load
//   multipliar_sign  in   shift {carry, hi, mplier} right by one
//   product_sign     in   add multiplicand into hi when mplier[0] is set
//   start_mult_sign  in   load operands and clear the accumulator
//   count_sign       in   increment the iteration counter
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module mult_datapath
   import mult_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   output logic [DATA_W-1:0] product_res,
   output logic [DATA_W-1:0] multipliar_res,
   output logic              stop,
   input  logic [DATA_W-1:0] multiplicant,
   input  logic [DATA_W-1:0] multipliar,
   input  logic              multipliar_sign,
   input  logic              product_sign,
   input  logic              start_mult_sign,
   input  logic              count_sign
);

   localparam logic [CNT_W-1:0] ITER_CNT = CNT_W'(ITERATIONS);

   logic [DATA_W-1:0] mcand_q,  mcand_d;
   logic              carry_q,  carry_d;
   logic [DATA_W-1:0] hi_q,     hi_d;
   logic [DATA_W-1:0] mplier_q, mplier_d;
   logic [CNT_W-1:0]  count_q,  count_d;

   logic [DATA_W:0]   add_sum;
   logic              done;

   assign done = (count_q == ITER_CNT);

   always_comb begin
      mcand_d  = mcand_q;
      carry_d  = carry_q;
      hi_d     = hi_q;
      mplier_d = mplier_q;
      count_d  = count_q;
      add_sum  = {1'b0, hi_q} + {1'b0, mcand_q};

      if (start_mult_sign) begin
         mcand_d  = multiplicant;
         mplier_d = multipliar;
         hi_d     = '0;
         carry_d  = 1'b0;
         count_d  = '0;
      end else if (!done) begin
         // The add decision uses the pre-shift LSB. The shift below then
         // works on the post-add value, so one cycle with both strobes is
         // one full iteration.
         if (product_sign && mplier_q[0]) begin
            {carry_d, hi_d} = add_sum;
         end
         if (multipliar_sign) begin
            {carry_d, hi_d, mplier_d} = {1'b0, carry_d, hi_d, mplier_d[DATA_W-1:1]};
         end
         // count never exceeds ITER_CNT because this branch is gated by done
         if (count_sign) begin
            count_d = count_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mcand_q  <= '0;
         carry_q  <= 1'b0;
         hi_q     <= '0;
         mplier_q <= '0;
         count_q  <= '0;
      end else begin
         mcand_q  <= mcand_d;
         carry_q  <= carry_d;
         hi_q     <= hi_d;
         mplier_q <= mplier_d;
         count_q  <= count_d;
      end
   end

   assign product_res    = hi_q;
   assign multipliar_res = mplier_q;
   assign stop           = done;

endmodule : mult_datapath

`default_nettype wire

// File: tb/tb_mult_datapath.sv
// ============================================================================
// Module      : tb_mult_datapath
// Description : Self-checking bench for mult_datapath. The reference model
//               is arithmetic: after k iterations, the 64-bit register pair
//               holds the partial product a*(b mod 2^k) in its top 32+k
//               bits and b>>k in its low 32-k bits.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mult_datapath;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] product_res;
   logic [31:0] multipliar_res;
   logic        stop;
   logic [31:0] multiplicant;
   logic [31:0] multipliar;
   logic        multipliar_sign;
   logic        product_sign;
   logic        start_mult_sign;
   logic        count_sign;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   mult_datapath dut (
      .clk            (clk),
      .rst            (rst),
      .product_res    (product_res),
      .multipliar_res (multipliar_res),
      .stop           (stop),
      .multiplicant   (multiplicant),
      .multipliar     (multipliar),
      .multipliar_sign(multipliar_sign),
      .product_sign   (product_sign),
      .start_mult_sign(start_mult_sign),
      .count_sign     (count_sign)
   );

   // Expected {product_res, multipliar_res} after k iterations.
   function automatic logic [63:0] partial(input logic [31:0] a, input logic [31:0] b, input int k);
      logic [63:0] mask;
      logic [63:0] pp;
      if (k >= 32) return {32'd0, a} * {32'd0, b};
      mask = (64'd1 << k) - 64'd1;
      pp   = ({32'd0, a} * ({32'd0, b} & mask)) << (32 - k);
      return pp | {32'd0, (b >> k)};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ctl(input logic st, input logic ad, input logic sh, input logic cn);
      start_mult_sign = st;
      product_sign    = ad;
      multipliar_sign = sh;
      count_sign      = cn;
   endtask

   task automatic load(input logic [31:0] a, input logic [31:0] b);
      multiplicant = a;
      multipliar   = b;
      set_ctl(1'b1, 1'b1, 1'b1, 1'b1);
      tick();
      set_ctl(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic run_fused(input int n);
      set_ctl(1'b0, 1'b1, 1'b1, 1'b1);
      for (int i = 0; i < n; i++) tick();
      set_ctl(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_total++;
      if (product_res !== 32'h0) $display("FAIL reset_product got=%h exp=%h", product_res, 32'h0);
      else n_pass++;
      n_total++;
      if (multipliar_res !== 32'h0) $display("FAIL reset_mplier got=%h exp=%h", multipliar_res, 32'h0);
      else n_pass++;
      n_total++;
      if (stop !== 1'b0) $display("FAIL reset_stop got=%b exp=0", stop);
      else n_pass++;
   endtask

   task automatic test_basic();
      load(32'd2, 32'd1);
      n_total++;
      if (stop !== 1'b0) $display("FAIL basic_stop_after_load got=%b exp=0", stop);
      else n_pass++;
      run_fused(31);
      n_total++;
      if (stop !== 1'b0) $display("FAIL basic_stop_at_31 got=%b exp=0", stop);
      else n_pass++;
      run_fused(1);
      n_total++;
      if ({product_res, multipliar_res} !== 64'd2)
         $display("FAIL basic_product got=%h_%h exp=%h", product_res, multipliar_res, 64'd2);
      else n_pass++;
      n_total++;
      if (stop !== 1'b1) $display("FAIL basic_stop_at_32 got=%b exp=1", stop);
      else n_pass++;
   endtask

   task automatic test_carry();
      logic [63:0] exp;
      exp = 64'hFFFFFFFE_00000001;
      load(32'hFFFFFFFF, 32'hFFFFFFFF);
      run_fused(32);
      n_total++;
      if ({product_res, multipliar_res} !== exp)
         $display("FAIL carry_fused got=%h_%h exp=%h", product_res, multipliar_res, exp);
      else n_pass++;
      // Same operands, but add and shift/count happen on separate cycles.
      load(32'hFFFFFFFF, 32'hFFFFFFFF);
      for (int i = 0; i < 32; i++) begin
         set_ctl(1'b0, 1'b1, 1'b0, 1'b0);
         tick();
         set_ctl(1'b0, 1'b0, 1'b1, 1'b1);
         tick();
      end
      set_ctl(1'b0, 1'b0, 1'b0, 1'b0);
      n_total++;
      if ({product_res, multipliar_res} !== exp || stop !== 1'b1)
         $display("FAIL carry_split got=%h_%h stop=%b exp=%h stop=1", product_res, multipliar_res, stop, exp);
      else n_pass++;
   endtask

   task automatic test_start_held();
      multipliar = 32'd1;
      set_ctl(1'b1, 1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 6; i++) begin
         multiplicant = $urandom;
         tick();
         n_total++;
         if (product_res !== 32'h0 || multipliar_res !== 32'h1 || stop !== 1'b0)
            $display("FAIL start_held cyc=%0d got=%h_%h stop=%b exp=00000000_00000001 stop=0",
                     i, product_res, multipliar_res, stop);
         else n_pass++;
      end
      set_ctl(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_after_stop();
      logic [63:0] held;
      logic [31:0] a, b;
      a = $urandom; b = $urandom;
      held = partial(a, b, 32);
      load(a, b);
      run_fused(32);
      set_ctl(1'b0, 1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 5; i++) tick();
      set_ctl(1'b0, 1'b0, 1'b0, 1'b0);
      n_total++;
      if ({product_res, multipliar_res} !== held || stop !== 1'b1)
         $display("FAIL after_stop_hold got=%h_%h stop=%b exp=%h stop=1", product_res, multipliar_res, stop, held);
      else n_pass++;
      load(32'd3, 32'd5);
      n_total++;
      if (stop !== 1'b0) $display("FAIL after_stop_reload_stop got=%b exp=0", stop);
      else n_pass++;
      run_fused(32);
      n_total++;
      if (product_res !== 32'h0 || multipliar_res !== 32'h0000000F)
         $display("FAIL after_stop_3x5 got=%h_%h exp=00000000_0000000f", product_res, multipliar_res);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      logic [31:0] a, b;
      a = $urandom | 32'h8000_0001; b = $urandom | 32'h0000_03FF;
      load(a, b);
      run_fused(10);
      n_total++;
      if ({product_res, multipliar_res} !== partial(a, b, 10))
         $display("FAIL mid_partial10 got=%h_%h exp=%h", product_res, multipliar_res, partial(a, b, 10));
      else n_pass++;
      rst = 1'b1;
      set_ctl(1'b0, 1'b1, 1'b1, 1'b1);
      tick();
      rst = 1'b0;
      set_ctl(1'b0, 1'b0, 1'b0, 1'b0);
      n_total++;
      if (product_res !== 32'h0 || multipliar_res !== 32'h0 || stop !== 1'b0)
         $display("FAIL mid_reset got=%h_%h stop=%b exp=0_0 stop=0", product_res, multipliar_res, stop);
      else n_pass++;
      // A fresh multiply must not see leftovers from the aborted one.
      a = $urandom; b = $urandom;
      load(a, b);
      run_fused(32);
      n_total++;
      if ({product_res, multipliar_res} !== partial(a, b, 32) || stop !== 1'b1)
         $display("FAIL mid_fresh got=%h_%h stop=%b exp=%h stop=1", product_res, multipliar_res, stop, partial(a, b, 32));
      else n_pass++;
   endtask

   task automatic test_random();
      logic [31:0] a, b;
      int k;
      for (int t = 0; t < 8; t++) begin
         a = $urandom;
         b = $urandom;
         if (t == 0) a = 32'hFFFF_FFFF;
         if (t == 1) b = 32'h0;
         load(a, b);
         k = 0;
         while (k < 32) begin
            case ($urandom_range(0, 3))
               0: begin
                  set_ctl(1'b0, 1'b0, 1'b0, 1'b0);
                  tick();
               end
               1: begin
                  set_ctl(1'b0, 1'b0, 1'b0, 1'b0);
                  set_ctl(1'b0, 1'b1, 1'b0, 1'b0);
                  tick();
                  set_ctl(1'b0, 1'b0, 1'b1, 1'b1);
                  tick();
                  k++;
               end
               default: begin
                  set_ctl(1'b0, 1'b1, 1'b1, 1'b1);
                  tick();
                  k++;
               end
            endcase
            set_ctl(1'b0, 1'b0, 1'b0, 1'b0);
            n_total++;
            if ({product_res, multipliar_res} !== partial(a, b, k) || stop !== (k == 32))
               $display("FAIL random t=%0d k=%0d got=%h_%h stop=%b exp=%h stop=%b",
                        t, k, product_res, multipliar_res, stop, partial(a, b, k), (k == 32));
            else n_pass++;
         end
      end
   endtask

   initial begin
      rst = 1'b0;
      multiplicant = '0;
      multipliar   = '0;
      set_ctl(1'b0, 1'b0, 1'b0, 1'b0);
      #2;
      test_reset();
      test_basic();
      test_carry();
      test_start_held();
      test_after_stop();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule : tb_mult_datapath

`default_nettype wire
